// File: rtl/bus_transfer_sequencer_if.sv
// Request/bus bundle between a transfer master and bus_transfer_sequencer.
interface bus_transfer_sequencer_if #(
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic                           ReqValid;
    logic                           ReqReady;
    logic [IW-1:0]                  ReqSrc;
    logic [IW-1:0]                  ReqDst;
    logic [NUM_REGS*DATA_WIDTH-1:0] RegDataOut;
    logic [NUM_REGS-1:0]            OutEnable;
    logic [NUM_REGS-1:0]            InEnable;
    logic [DATA_WIDTH-1:0]          Bus;
    logic                           Done;
    logic                           Error;
    logic                           ContentionError;

    modport master (
        output ReqValid, ReqSrc, ReqDst, RegDataOut,
        input  ReqReady, OutEnable, InEnable, Bus, Done, Error, ContentionError
    );

    modport slave (
        input  ReqValid, ReqSrc, ReqDst, RegDataOut,
        output ReqReady, OutEnable, InEnable, Bus, Done, Error, ContentionError
    );
endinterface

// File: rtl/bus_transfer_sequencer.sv
// Sequences one register-to-register transfer: drive source, settle, latch destination.
// Optional feature macro: BUS_CONTENTION_CHECK_EN (sticky contention flag).
module bus_transfer_sequencer #(
    parameter int unsigned NUM_REGS      = 8,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic clock,
    input  logic reset_n,
    bus_transfer_sequencer_if.slave bus
);
    localparam int unsigned IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned CW = 4;

    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_LATCH, S_DONE, S_ERR} state_e;

    state_e              state_q, state_d;
    logic [IW-1:0]       src_q, src_d;
    logic [IW-1:0]       dst_q, dst_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_REGS-1:0] out_enable_q, out_enable_d;
    logic [NUM_REGS-1:0] in_enable_q, in_enable_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                req_ready_q, req_ready_d;
    logic                bad_req_c;
    logic [DATA_WIDTH-1:0] bus_c;

    // State and registered outputs; reset aborts any transfer in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            cnt_q        <= '0;
            out_enable_q <= '0;
            in_enable_q  <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            cnt_q        <= cnt_d;
            out_enable_q <= out_enable_d;
            in_enable_q  <= in_enable_d;
            done_q       <= done_d;
            error_q      <= error_d;
            req_ready_q  <= req_ready_d;
        end
    end

    assign bad_req_c = (32'(bus.ReqSrc) >= NUM_REGS) || (32'(bus.ReqDst) >= NUM_REGS)
                    || (bus.ReqSrc == bus.ReqDst);

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.ReqValid) begin
                    src_d = bus.ReqSrc;
                    dst_d = bus.ReqDst;
                    if (bad_req_c) begin
                        state_d = S_ERR;
                    end else if (SETTLE_CYCLES > 0) begin
                        state_d = S_DRIVE;
                        cnt_d   = CW'(SETTLE_CYCLES - 1);
                    end else begin
                        state_d = S_LATCH;
                    end
                end
            end
            S_DRIVE: begin
                if (cnt_q == '0) state_d = S_LATCH;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_LATCH: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        out_enable_d = '0;
        in_enable_d  = '0;
        done_d       = 1'b0;
        error_d      = 1'b0;
        req_ready_d  = (state_d == S_IDLE);
        case (state_d)
            S_DRIVE: out_enable_d = NUM_REGS'(1) << src_d;
            S_LATCH: begin
                out_enable_d = NUM_REGS'(1) << src_d;
                in_enable_d  = NUM_REGS'(1) << dst_d;
            end
            S_DONE:  done_d  = 1'b1;
            S_ERR:   error_d = 1'b1;
            default: ;
        endcase
    end

    // Wired-OR of all register outputs onto the shared bus.
    always_comb begin
        bus_c = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            bus_c = bus_c | bus.RegDataOut[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef BUS_CONTENTION_CHECK_EN
    logic contention_q, contention_d;

    // Only the selected source may drive while a transfer holds the bus.
    always_comb begin
        contention_d = contention_q;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (bus.RegDataOut[i*DATA_WIDTH +: DATA_WIDTH] != '0) begin
                if (!(((state_q == S_DRIVE) || (state_q == S_LATCH)) && (32'(src_q) == i))) begin
                    contention_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) contention_q <= 1'b0;
        else          contention_q <= contention_d;
    end

    assign bus.ContentionError = contention_q;
`else
    assign bus.ContentionError = 1'b0;
`endif

    assign bus.ReqReady  = req_ready_q;
    assign bus.OutEnable = out_enable_q;
    assign bus.InEnable  = in_enable_q;
    assign bus.Bus       = bus_c;
    assign bus.Done      = done_q;
    assign bus.Error     = error_q;
endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Directed bench: SETTLE_CYCLES=1 instance (a) and SETTLE_CYCLES=0 instance (b) with a register-bank model.
module tb_bus_transfer_sequencer;
    localparam int unsigned NR = 8;
    localparam int unsigned DW = 32;
`ifdef BUS_CONTENTION_CHECK_EN
    localparam logic CONT_EN = 1'b1;
`else
    localparam logic CONT_EN = 1'b0;
`endif

    typedef struct {
        int          which;
        int unsigned dst;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    logic [DW-1:0] regs_a [NR];
    logic [DW-1:0] regs_b [NR];
    logic [DW-1:0] force_a4;

    always #5 clk = ~clk;

    bus_transfer_sequencer_if #(.NUM_REGS(NR), .DATA_WIDTH(DW)) a_if ();
    bus_transfer_sequencer_if #(.NUM_REGS(NR), .DATA_WIDTH(DW)) b_if ();

    bus_transfer_sequencer #(.NUM_REGS(NR), .DATA_WIDTH(DW), .SETTLE_CYCLES(1)) dut_a (
        .clock(clk), .reset_n(rst_n), .bus(a_if));
    bus_transfer_sequencer #(.NUM_REGS(NR), .DATA_WIDTH(DW), .SETTLE_CYCLES(0)) dut_b (
        .clock(clk), .reset_n(rst_n), .bus(b_if));

    // Register banks: drive only when enabled, capture Bus on load enable.
    always_comb begin
        a_if.RegDataOut = '0;
        b_if.RegDataOut = '0;
        for (int i = 0; i < NR; i++) begin
            if (a_if.OutEnable[i]) a_if.RegDataOut[i*DW +: DW] = regs_a[i];
            if (b_if.OutEnable[i]) b_if.RegDataOut[i*DW +: DW] = regs_b[i];
        end
        a_if.RegDataOut[4*DW +: DW] = a_if.RegDataOut[4*DW +: DW] | force_a4;
    end

    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (a_if.InEnable[i]) regs_a[i] <= a_if.Bus;
            if (b_if.InEnable[i]) regs_b[i] <= b_if.Bus;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_pop(input int which);
        exp_t e;
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_which", 64'(e.which), 64'(which));
            if (e.which == 0) chk("sb_data_a", 64'(regs_a[e.dst]), 64'(e.data));
            else              chk("sb_data_b", 64'(regs_b[e.dst]), 64'(e.data));
        end
    endtask

    task automatic wait_done_a();
        for (int n = 0; n < 20 && !a_if.Done; n++) tick();
        chk("wait_done_a", 64'(a_if.Done), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        force_a4 = '0;
        a_if.ReqValid = 1'b0; a_if.ReqSrc = '0; a_if.ReqDst = '0;
        b_if.ReqValid = 1'b0; b_if.ReqSrc = '0; b_if.ReqDst = '0;
        for (int i = 0; i < NR; i++) begin
            regs_a[i] <= 32'h0;
            regs_b[i] <= 32'h0;
        end
        regs_a[1] <= 32'hA5A5A5A5;
        regs_a[2] <= 32'hDEADBEEF;
        regs_a[3] <= 32'h00000011;
        regs_a[4] <= 32'h0BADF00D;
        regs_a[7] <= 32'h00000077;
        regs_b[0] <= 32'h12345678;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_ready", 64'(a_if.ReqReady), 64'd1);
        chk("rst_out", 64'(a_if.OutEnable), 64'd0);
        chk("rst_in", 64'(a_if.InEnable), 64'd0);
        chk("rst_done", 64'(a_if.Done), 64'd0);
        chk("rst_err", 64'(a_if.Error), 64'd0);
        chk("rst_cont", 64'(a_if.ContentionError), 64'd0);
        chk("rst_bus", 64'(a_if.Bus), 64'd0);
        chk("rst_ready_b", 64'(b_if.ReqReady), 64'd1);

        // Test 1: reg2 -> reg5, S=1
        a_if.ReqValid = 1'b1; a_if.ReqSrc = 3'd2; a_if.ReqDst = 3'd5;
        sb.push_back('{0, 5, 32'hDEADBEEF});
        tick();
        a_if.ReqValid = 1'b0;
        chk("t1_drive_out", 64'(a_if.OutEnable), 64'h04);
        chk("t1_drive_in", 64'(a_if.InEnable), 64'h00);
        chk("t1_drive_ready", 64'(a_if.ReqReady), 64'd0);
        tick();
        chk("t1_latch_out", 64'(a_if.OutEnable), 64'h04);
        chk("t1_latch_in", 64'(a_if.InEnable), 64'h20);
        chk("t1_latch_bus", 64'(a_if.Bus), 64'hDEADBEEF);
        tick();
        chk("t1_done", 64'(a_if.Done), 64'd1);
        chk("t1_done_out", 64'(a_if.OutEnable), 64'h00);
        chk("t1_done_in", 64'(a_if.InEnable), 64'h00);
        sb_pop(0);
        tick();
        chk("t1_ready_back", 64'(a_if.ReqReady), 64'd1);
        chk("t1_done_pulse", 64'(a_if.Done), 64'd0);

        // Test 2: src == dst rejected
        a_if.ReqValid = 1'b1; a_if.ReqSrc = 3'd3; a_if.ReqDst = 3'd3;
        tick();
        a_if.ReqValid = 1'b0;
        chk("t2_err", 64'(a_if.Error), 64'd1);
        chk("t2_done", 64'(a_if.Done), 64'd0);
        chk("t2_out", 64'(a_if.OutEnable), 64'h00);
        chk("t2_in", 64'(a_if.InEnable), 64'h00);
        tick();
        chk("t2_err_pulse", 64'(a_if.Error), 64'd0);
        chk("t2_done2", 64'(a_if.Done), 64'd0);
        chk("t2_ready", 64'(a_if.ReqReady), 64'd1);

        // Test 3: S=0, reg0 -> reg7 on instance b
        b_if.ReqValid = 1'b1; b_if.ReqSrc = 3'd0; b_if.ReqDst = 3'd7;
        sb.push_back('{1, 7, 32'h12345678});
        tick();
        b_if.ReqValid = 1'b0;
        chk("t3_latch_out", 64'(b_if.OutEnable), 64'h01);
        chk("t3_latch_in", 64'(b_if.InEnable), 64'h80);
        tick();
        chk("t3_done", 64'(b_if.Done), 64'd1);
        sb_pop(1);
        tick();
        chk("t3_ready", 64'(b_if.ReqReady), 64'd1);

        // Test 4: new request held during a transfer is ignored until IDLE
        a_if.ReqValid = 1'b1; a_if.ReqSrc = 3'd1; a_if.ReqDst = 3'd6;
        sb.push_back('{0, 6, 32'hA5A5A5A5});
        tick();
        a_if.ReqSrc = 3'd4; a_if.ReqDst = 3'd0;
        chk("t4_ready_busy", 64'(a_if.ReqReady), 64'd0);
        chk("t4_drive_out", 64'(a_if.OutEnable), 64'h02);
        tick();
        chk("t4_latch_in", 64'(a_if.InEnable), 64'h40);
        chk("t4_latch_out", 64'(a_if.OutEnable), 64'h02);
        tick();
        chk("t4_done", 64'(a_if.Done), 64'd1);
        chk("t4_ready_done", 64'(a_if.ReqReady), 64'd0);
        sb_pop(0);
        tick();
        chk("t4_ready_idle", 64'(a_if.ReqReady), 64'd1);
        sb.push_back('{0, 0, 32'h0BADF00D});
        tick();
        a_if.ReqValid = 1'b0;
        chk("t4_second_out", 64'(a_if.OutEnable), 64'h10);
        wait_done_a();
        sb_pop(0);
        tick();

        // Test 5: reset during DRIVE aborts with no load
        a_if.ReqValid = 1'b1; a_if.ReqSrc = 3'd3; a_if.ReqDst = 3'd7;
        tick();
        a_if.ReqValid = 1'b0;
        chk("t5_drive_out", 64'(a_if.OutEnable), 64'h08);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_out", 64'(a_if.OutEnable), 64'h00);
        chk("t5_rst_in", 64'(a_if.InEnable), 64'h00);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("t5_ready", 64'(a_if.ReqReady), 64'd1);
        chk("t5_dst_kept", 64'(regs_a[7]), 64'h00000077);
        chk("t5_done", 64'(a_if.Done), 64'd0);

        // Test 6: reg4 driven during a transfer from reg2
        force_a4 = 32'h1;
        a_if.ReqValid = 1'b1; a_if.ReqSrc = 3'd2; a_if.ReqDst = 3'd3;
        sb.push_back('{0, 3, 32'hDEADBEEF});
        tick();
        a_if.ReqValid = 1'b0;
        chk("t6_bus_or", 64'(a_if.Bus), 64'hDEADBEEF);
        wait_done_a();
        sb_pop(0);
        chk("t6_cont", 64'(a_if.ContentionError), 64'(CONT_EN));
        force_a4 = '0;
        tick(); tick();
        chk("t6_cont_sticky", 64'(a_if.ContentionError), 64'(CONT_EN));
        rst_n = 1'b0;
        #1;
        chk("t6_cont_rst", 64'(a_if.ContentionError), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_cont_after", 64'(a_if.ContentionError), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
